// File: rtl/upscale.sv
// upscale: signed pixel to signed number expander, two-stage stallable pipe.
// Define UPSCALE_SAT_EN to clamp out-of-range results (otherwise wrap-around).
module upscale #(
    parameter int IMG_WIDTH = 16,
    parameter int NUM_WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           shift,
    input  logic [IMG_WIDTH-1:0] up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int WW = IMG_WIDTH + NUM_WIDTH;
    localparam int TW = IMG_WIDTH + 1;
    localparam logic [7:0] SMAX = 8'(NUM_WIDTH - 1);

    localparam logic [NUM_WIDTH-1:0] NUM_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic [NUM_WIDTH-1:0] NUM_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    logic                 en;
    logic [7:0]           shamt;
    logic [WW-1:0]        px_ext;
    logic [WW-1:0]        wide;

    logic                 s1_valid_q, s1_valid_d;
    logic [WW-1:0]        s1_data_q, s1_data_d;
    logic                 dn_valid_q, dn_valid_d;
    logic [NUM_WIDTH-1:0] dn_data_q, dn_data_d;
    logic                 ovf_q, ovf_d;

    logic [TW-1:0]        top;
    logic                 in_range;
    logic                 above;
    logic                 below;
    logic                 ovf_evt;
    logic [NUM_WIDTH-1:0] result;

    // Advance enable; stage 1 may also fill a bubble while the output stalls
    always_comb begin
        en       = ~dn_valid_q | dn_ready;
        up_ready = en | ~s1_valid_q;
    end

    // Clamp the shift and widen the incoming pixel
    always_comb begin
        shamt  = (shift > SMAX) ? SMAX : shift;
        px_ext = {{NUM_WIDTH{up_data[IMG_WIDTH-1]}}, up_data};
        wide   = px_ext << shamt;
    end

    // Stage 1 loads whenever it is free or draining into stage 2
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (up_ready) begin
            s1_valid_d = up_valid;
            if (up_valid) begin
                s1_data_d = wide;
            end
        end
    end

    // Range check of the wide value and the result it produces
    always_comb begin
        top      = s1_data_q[WW-1 -: TW];
        in_range = (top == '0) || (top == '1);
        above    = ~s1_data_q[WW-1] & ~in_range;
        below    = s1_data_q[WW-1] & ~in_range;
        result   = s1_data_q[NUM_WIDTH-1:0];
`ifdef UPSCALE_SAT_EN
        unique case (1'b1)
            above:   result = NUM_MAX;
            below:   result = NUM_MIN;
            default: result = s1_data_q[NUM_WIDTH-1:0];
        endcase
`endif
    end

    // Output stage and sticky overflow; a new event beats a clear
    always_comb begin
        dn_valid_d = dn_valid_q;
        dn_data_d  = dn_data_q;
        ovf_evt    = en & s1_valid_q & (above | below);
        if (en) begin
            dn_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dn_data_d = result;
            end
        end
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            dn_valid_q <= 1'b0;
            dn_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            dn_valid_q <= dn_valid_d;
            dn_data_q  <= dn_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dn_data  = dn_data_q;
    assign dn_valid = dn_valid_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_upscale.sv
// tb_upscale: directed and randomized scoreboard bench for upscale.
// Expected values follow UPSCALE_SAT_EN the same way the design does.
module tb_upscale;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  shift = '0;
    logic [15:0] up_data = '0;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [32:0] dn_data;
    logic        dn_valid;
    logic        dn_ready = 1'b0;
    logic        ovf;
    logic        ovf_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    always #5 clk = ~clk;

    upscale dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift    (shift),
        .up_data  (up_data),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .dn_data  (dn_data),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    // Reference: exact integer arithmetic, then clamp or wrap
    function automatic logic [32:0] model(input logic [15:0] px,
                                          input logic [7:0] sh);
        longint v;
        int     s;
        s = (sh > 8'd32) ? 32 : int'(sh);
        v = longint'($signed(px));
        v = v * (longint'(1) << s);
`ifdef UPSCALE_SAT_EN
        if (v > 64'sd4294967295) return 33'h0_FFFF_FFFF;
        if (v < -64'sd4294967296) return 33'h1_0000_0000;
`endif
        return v[32:0];
    endfunction

    // One clock: record handshakes seen at the edge, return at edge+1
    task automatic cycle();
        @(negedge clk);
        if (up_valid && up_ready) exp_q.push_back(model(up_data, shift));
        if (dn_valid && dn_ready) got_q.push_back(dn_data);
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send_one(input logic [15:0] px, input logic [7:0] sh);
        int n0;
        int k;
        n0 = exp_q.size();
        k = 0;
        up_data = px;
        shift = sh;
        up_valid = 1'b1;
        while (exp_q.size() == n0 && k < 10) begin
            cycle();
            k++;
        end
        up_valid = 1'b0;
        if (exp_q.size() == n0) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: px %h not accepted", px);
        end
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        while (got_q.size() == 0 && k < 10) begin
            cycle();
            k++;
        end
        if (got_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_timeout: no output produced");
            got_q.push_back('x);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if (dn_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_dn_valid: got %b want 0", dn_valid);
        end
        tests++;
        if (dn_data !== 33'h0) begin
            fails++;
            $display("FAIL rst_dn_data: got %h want 0", dn_data);
        end
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL rst_ovf: got %b want 0", ovf);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dn_ready = 1'b1;
        cycle();
        tests++;
        if (up_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_up_ready: got %b want 1", up_ready);
        end
    endtask

    task automatic test_basic();
        flush();
        dn_ready = 1'b1;
        up_data = 16'h0003;
        shift = 8'd4;
        up_valid = 1'b1;
        cycle();
        up_valid = 1'b0;
        tests++;
        if (dn_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early: dn_valid %b want 0", dn_valid);
        end
        cycle();
        tests++;
        if (dn_valid !== 1'b1 || dn_data !== 33'h0_0000_0030) begin
            fails++;
            $display("FAIL basic_data: got %b/%h want 1/000000030",
                     dn_valid, dn_data);
        end
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL basic_ovf: got %b want 0", ovf);
        end
        cycle();
    endtask

    task automatic test_neg_edge();
        logic [32:0] got;
        logic [32:0] want;
        flush();
        send_one(16'h8000, 8'd17);
        wait_out();
        got = got_q.pop_front();
        tests++;
        if (got !== 33'h1_0000_0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL neg_min: got %h ovf %b want 100000000 ovf 0",
                     got, ovf);
        end
        send_one(16'h8000, 8'd18);
        wait_out();
        got = got_q.pop_front();
`ifdef UPSCALE_SAT_EN
        want = 33'h1_0000_0000;
`else
        want = 33'h0_0000_0000;
`endif
        tests++;
        if (got !== want || ovf !== 1'b1) begin
            fails++;
            $display("FAIL neg_ovf: got %h ovf %b want %h ovf 1",
                     got, ovf, want);
        end
    endtask

    task automatic test_ovf();
        logic [32:0] got;
        logic [32:0] want;
        flush();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        send_one(16'h7FFF, 8'd18);
        wait_out();
        got = got_q.pop_front();
`ifdef UPSCALE_SAT_EN
        want = 33'h0_FFFF_FFFF;
`else
        want = 33'h1_FFFC_0000;
`endif
        tests++;
        if (got !== want || ovf !== 1'b1) begin
            fails++;
            $display("FAIL pos_sat: got %h ovf %b want %h ovf 1",
                     got, ovf, want);
        end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clr: got %b want 0", ovf);
        end
        send_one(16'h7FFF, 8'd18);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        tests++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set_wins: got %b want 1", ovf);
        end
        wait_out();
        flush();
    endtask

    task automatic test_shift_clamp();
        logic [32:0] got;
        logic [32:0] want;
        flush();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        send_one(16'h0000, 8'd200);
        wait_out();
        got = got_q.pop_front();
        tests++;
        if (got !== 33'h0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL clamp_zero: got %h ovf %b want 0 ovf 0", got, ovf);
        end
        send_one(16'h0001, 8'd200);
        wait_out();
        got = got_q.pop_front();
`ifdef UPSCALE_SAT_EN
        want = 33'h0_FFFF_FFFF;
`else
        want = 33'h1_0000_0000;
`endif
        tests++;
        if (got !== want || ovf !== 1'b1) begin
            fails++;
            $display("FAIL clamp_one: got %h ovf %b want %h ovf 1",
                     got, ovf, want);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int n0;
        logic [32:0] hold;
        logic [32:0] got;
        flush();
        idx = 1;
        hold = '0;
        for (int c = 0; c < 60 && got_q.size() < 6; c++) begin
            dn_ready = !(c >= 3 && c < 8);
            up_valid = (idx <= 6);
            up_data = 16'(idx);
            shift = 8'd0;
            n0 = exp_q.size();
            cycle();
            if (exp_q.size() != n0) idx++;
            if (c == 4) hold = dn_data;
            if (c == 6) begin
                tests++;
                if (up_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_up_ready: got %b want 0", up_ready);
                end
                tests++;
                if (dn_valid !== 1'b1 || dn_data !== hold) begin
                    fails++;
                    $display("FAIL bp_hold: got %b/%h want 1/%h",
                             dn_valid, dn_data, hold);
                end
            end
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        tests++;
        if (got_q.size() != 6) begin
            fails++;
            $display("FAIL bp_count: got %0d want 6", got_q.size());
        end
        for (int i = 0; i < 6 && got_q.size() > 0; i++) begin
            got = got_q.pop_front();
            tests++;
            if (got !== 33'(i + 1)) begin
                fails++;
                $display("FAIL bp_seq[%0d]: got %h want %h", i, got,
                         33'(i + 1));
            end
        end
        flush();
    endtask

    task automatic test_random();
        int n_acc;
        int n_got;
        int n0;
        logic [32:0] got;
        logic [32:0] want;
        flush();
        n_acc = 0;
        n_got = 0;
        for (int c = 0; c < 20000 && n_got < 1000; c++) begin
            up_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            up_data = 16'($urandom());
            shift = 8'($urandom_range(0, 40));
            dn_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = 1'b0;
            n0 = exp_q.size();
            cycle();
            n_acc += exp_q.size() - n0;
            while (got_q.size() > 0) begin
                got = got_q.pop_front();
                n_got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_extra: got %h want none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        fails++;
                        $display("FAIL rand[%0d]: got %h want %h",
                                 n_got, got, want);
                    end
                end
            end
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        tests++;
        if (n_got != 1000) begin
            fails++;
            $display("FAIL rand_count: got %0d want 1000", n_got);
        end
        flush();
    endtask

    task automatic test_reset_midstream();
        flush();
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        dn_ready = 1'b0;
        send_one(16'h7FFF, 8'd18);
        send_one(16'h0005, 8'd0);
        tests++;
        if (dn_valid !== 1'b1 || ovf !== 1'b1 || up_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_full: got v%b ovf%b rdy%b want 1 1 0",
                     dn_valid, ovf, up_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (dn_valid !== 1'b0 || dn_data !== 33'h0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: got v%b d%h ovf%b want 0 0 0",
                     dn_valid, dn_data, ovf);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        flush();
        dn_ready = 1'b1;
        cycle();
        tests++;
        if (up_ready !== 1'b1 || dn_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_idle: got rdy%b v%b want 1 0",
                     up_ready, dn_valid);
        end
        up_data = 16'h0005;
        shift = 8'd1;
        up_valid = 1'b1;
        cycle();
        up_valid = 1'b0;
        tests++;
        if (dn_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_early: dn_valid %b want 0", dn_valid);
        end
        cycle();
        tests++;
        if (dn_valid !== 1'b1 || dn_data !== 33'h0_0000_000A) begin
            fails++;
            $display("FAIL mid_after: got %b/%h want 1/00000000a",
                     dn_valid, dn_data);
        end
        for (int i = 0; i < 4; i++) cycle();
        tests++;
        if (got_q.size() != 1) begin
            fails++;
            $display("FAIL mid_stale: got %0d outputs want 1", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_edge();
        test_ovf();
        test_shift_clamp();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
